// File: rtl/imm_encoder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imm_encoder_pkg
// Description : Shared types, opcodes and immediate range limits for the
//               immediate encoder (inverse of the core's immediate decoder).
// Revision    : 1.0 - initial release
// ============================================================================
package imm_encoder_pkg;

    typedef logic [31:0] data_bus_t;

    // Instruction immediate formats; encodings outside this set pack as Imm
    typedef enum logic [2:0] {
        FMT_IMM    = 3'd0,
        FMT_STORE  = 3'd1,
        FMT_UPPER  = 3'd2,
        FMT_BRANCH = 3'd3,
        FMT_JUMP   = 3'd4
    } instr_format_t;

    // Encoder sequencing: single word / second word of a LUI+I-type pair
    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_SECOND = 1'b1
    } enc_state_t;

    localparam logic [6:0] OPC_LUI = 7'b0110111;

    localparam int IMM12_MIN = -2048;
    localparam int IMM12_MAX = 2047;
    localparam int BIMM_MIN  = -4096;
    localparam int BIMM_MAX  = 4094;
    localparam int JIMM_MIN  = -1048576;
    localparam int JIMM_MAX  = 1048574;

    // Signed inclusive range test of a 32-bit value
    function automatic logic in_range(input data_bus_t v, input int lo, input int hi);
        return ($signed(v) >= lo) && ($signed(v) <= hi);
    endfunction

    // Upper 20 bits of (imm + 0x800) mod 2^32: the carry into bit 12 is imm[11]
    function automatic logic [19:0] lui_hi(input data_bus_t imm);
        return imm[31:12] + {19'd0, imm[11]};
    endfunction

endpackage : imm_encoder_pkg
`default_nettype wire

// File: rtl/imm_encoder_pack.sv
`default_nettype none
// ============================================================================
// Module      : imm_encoder_pack
// Description : Combinational scatter of an immediate into the instruction
//               bit positions of a format, merged with a template word, plus
//               the representability check (range and alignment).
// Revision    : 1.0 - initial release
// ============================================================================
module imm_encoder_pack
    import imm_encoder_pkg::*;
(
    input  data_bus_t     i_template,
    input  instr_format_t i_fmt,
    input  data_bus_t     i_imm,
    output data_bus_t     o_instr,
    output logic          o_err
);

    // Scatter the immediate per format and flag values the field cannot hold
    always_comb begin
        o_instr = i_template;
        o_err   = 1'b0;
        case (i_fmt)
            FMT_STORE: begin
                o_instr[31:25] = i_imm[11:5];
                o_instr[11:7]  = i_imm[4:0];
                o_err          = !in_range(i_imm, IMM12_MIN, IMM12_MAX);
            end
            FMT_UPPER: begin
                o_instr[31:12] = i_imm[31:12];
                o_err          = (i_imm[11:0] != 12'd0);
            end
            FMT_BRANCH: begin
                o_instr[31]    = i_imm[12];
                o_instr[30:25] = i_imm[10:5];
                o_instr[11:8]  = i_imm[4:1];
                o_instr[7]     = i_imm[11];
                o_err          = !in_range(i_imm, BIMM_MIN, BIMM_MAX) || i_imm[0];
            end
            FMT_JUMP: begin
                o_instr[31]    = i_imm[20];
                o_instr[30:21] = i_imm[10:1];
                o_instr[20]    = i_imm[11];
                o_instr[19:12] = i_imm[19:12];
                o_err          = !in_range(i_imm, JIMM_MIN, JIMM_MAX) || i_imm[0];
            end
            default: begin
                o_instr[31:20] = i_imm[11:0];
                o_err          = !in_range(i_imm, IMM12_MIN, IMM12_MAX);
            end
        endcase
    end

endmodule : imm_encoder_pack
`default_nettype wire

// File: rtl/imm_encoder.sv
`default_nettype none
// ============================================================================
// Module      : imm_encoder
// Description : Encodes an immediate into an instruction template with a
//               registered valid/ready output. Out-of-range Imm requests with
//               expansion enabled emit a LUI + I-type pair. Counts (saturating)
//               words delivered with the error flag set.
// Revision    : 1.0 - initial release
// ============================================================================
module imm_encoder
    import imm_encoder_pkg::*;
#(
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  data_bus_t            in_template,
    input  instr_format_t        in_fmt,
    input  data_bus_t            in_imm,
    input  logic                 in_expand,
    output logic                 out_valid,
    input  logic                 out_ready,
    output data_bus_t            out_instr,
    output logic                 out_last,
    output logic                 out_err,
    output logic [ERR_CNT_W-1:0] err_count
);

    enc_state_t           state_q,     state_d;
    logic                 out_valid_q, out_valid_d;
    data_bus_t            out_instr_q, out_instr_d;
    logic                 out_last_q,  out_last_d;
    logic                 out_err_q,   out_err_d;
    logic [ERR_CNT_W-1:0] err_count_q, err_count_d;
    logic [14:0]          tmpl_q,      tmpl_d;   // template bits kept for word 2
    logic [11:0]          imm_lo_q,    imm_lo_d; // low immediate for word 2

    data_bus_t w_pack_instr;
    logic      w_pack_err;
    logic      w_is_imm;
    logic      w_expand;
    logic      w_accept;
    logic      w_fire;

    imm_encoder_pack u_pack (
        .i_template (in_template),
        .i_fmt      (in_fmt),
        .i_imm      (in_imm),
        .o_instr    (w_pack_instr),
        .o_err      (w_pack_err)
    );

    // Handshake qualifiers and the expansion decision for the incoming request
    always_comb begin
        w_is_imm = !(in_fmt inside {FMT_STORE, FMT_UPPER, FMT_BRANCH, FMT_JUMP});
        w_expand = in_expand && w_is_imm && !in_range(in_imm, IMM12_MIN, IMM12_MAX);
        in_ready = (state_q == ST_IDLE) && (!out_valid_q || out_ready);
        w_accept = in_valid && in_ready;
        w_fire   = out_valid_q && out_ready;
    end

    // Next-state: output register, pair sequencing and error counting
    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_instr_d = out_instr_q;
        out_last_d  = out_last_q;
        out_err_d   = out_err_q;
        err_count_d = err_count_q;
        tmpl_d      = tmpl_q;
        imm_lo_d    = imm_lo_q;

        if (w_fire) begin
            out_valid_d = 1'b0;
            if (out_err_q && (err_count_q != {ERR_CNT_W{1'b1}})) begin
                err_count_d = err_count_q + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
            end
        end

        case (state_q)
            ST_SECOND: begin
                if (w_fire) begin
                    if (!out_last_q) begin
                        // Word 1 consumed: ADDI-style word sourcing rs1 = rd
                        out_valid_d = 1'b1;
                        out_instr_d = {imm_lo_q, tmpl_q[11:7], tmpl_q[14:0]};
                        out_last_d  = 1'b1;
                        out_err_d   = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                if (w_accept) begin
                    out_valid_d = 1'b1;
                    if (w_expand) begin
                        out_instr_d = {lui_hi(in_imm), in_template[11:7], OPC_LUI};
                        out_last_d  = 1'b0;
                        out_err_d   = 1'b0;
                        tmpl_d      = in_template[14:0];
                        imm_lo_d    = in_imm[11:0];
                        state_d     = ST_SECOND;
                    end else begin
                        out_instr_d = w_pack_instr;
                        out_last_d  = 1'b1;
                        out_err_d   = w_pack_err;
                    end
                end
            end
        endcase
    end

    // State and output registers; reset drops any pending second word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            out_instr_q <= '0;
            out_last_q  <= 1'b0;
            out_err_q   <= 1'b0;
            err_count_q <= '0;
            tmpl_q      <= '0;
            imm_lo_q    <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_instr_q <= out_instr_d;
            out_last_q  <= out_last_d;
            out_err_q   <= out_err_d;
            err_count_q <= err_count_d;
            tmpl_q      <= tmpl_d;
            imm_lo_q    <= imm_lo_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_instr = out_instr_q;
    assign out_last  = out_last_q;
    assign out_err   = out_err_q;
    assign err_count = err_count_q;

endmodule : imm_encoder
`default_nettype wire

// File: tb/tb_imm_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_imm_encoder
// Description : Directed self-checking bench for imm_encoder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imm_encoder;
    import imm_encoder_pkg::*;

    localparam int ERR_CNT_W = 8;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    data_bus_t            in_template;
    instr_format_t        in_fmt;
    data_bus_t            in_imm;
    logic                 in_expand;
    logic                 out_valid;
    logic                 out_ready;
    data_bus_t            out_instr;
    logic                 out_last;
    logic                 out_err;
    logic [ERR_CNT_W-1:0] err_count;

    int tests_run = 0;
    int tests_failed = 0;

    imm_encoder #(.ERR_CNT_W(ERR_CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_template (in_template),
        .in_fmt      (in_fmt),
        .in_imm      (in_imm),
        .in_expand   (in_expand),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_last    (out_last),
        .out_err     (out_err),
        .err_count   (err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just past the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one request for exactly one cycle (in_ready checked first)
    task automatic send(input string tag, input data_bus_t t, input instr_format_t f,
                        input data_bus_t imm, input logic ex);
        chk({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
        in_valid    = 1'b1;
        in_template = t;
        in_fmt      = f;
        in_imm      = imm;
        in_expand   = ex;
        tick();
        in_valid    = 1'b0;
        in_expand   = 1'b0;
    endtask

    task automatic chk_word(input string tag, input data_bus_t instr, input logic last,
                            input logic err);
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "_instr"}, out_instr, instr);
        chk({tag, "_last"},  {31'd0, out_last}, {31'd0, last});
        chk({tag, "_err"},   {31'd0, out_err},  {31'd0, err});
    endtask

    initial begin
        rst         = 1'b1;
        in_valid    = 1'b0;
        in_template = '0;
        in_fmt      = FMT_IMM;
        in_imm      = '0;
        in_expand   = 1'b0;
        out_ready   = 1'b1;
        tick();
        tick();
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_instr", out_instr, 32'd0);
        chk("rst_last",  {31'd0, out_last}, 32'd0);
        chk("rst_err",   {31'd0, out_err}, 32'd0);
        chk("rst_cnt",   {24'd0, err_count}, 32'd0);
        rst = 1'b0;
        tick();

        // Imm, negative value
        send("imm_m1", 32'h0000_0293, FMT_IMM, 32'hFFFF_FFFF, 1'b0);
        chk_word("imm_m1", 32'hFFF0_0293, 1'b1, 1'b0);

        // Branch at the positive limit, then misaligned back-to-back
        send("br_max", 32'h0000_0063, FMT_BRANCH, 32'd4094, 1'b0);
        chk_word("br_max", 32'h7E00_0FE3, 1'b1, 1'b0);
        send("br_odd", 32'h0000_0063, FMT_BRANCH, 32'd3, 1'b0);
        chk("br_odd_err", {31'd0, out_err}, 32'd1);
        tick();
        chk("br_odd_cnt", {24'd0, err_count}, 32'd1);
        chk("br_odd_idle", {31'd0, out_valid}, 32'd0);

        // Expansion pair, consumer always ready
        send("exp", 32'h0000_0293, FMT_IMM, 32'h1234_5FFF, 1'b1);
        chk_word("exp_w1", 32'h1234_62B7, 1'b0, 1'b0);
        chk("exp_w1_inrdy", {31'd0, in_ready}, 32'd0);
        tick();
        chk_word("exp_w2", 32'hFFF2_8293, 1'b1, 1'b0);
        chk("exp_w2_inrdy", {31'd0, in_ready}, 32'd0);
        tick();
        chk("exp_done_valid", {31'd0, out_valid}, 32'd0);

        // Expansion pair with backpressure on word 1
        out_ready = 1'b0;
        send("bp", 32'h0000_0293, FMT_IMM, 32'h1234_5FFF, 1'b1);
        chk_word("bp_w1", 32'h1234_62B7, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_hold_instr", out_instr, 32'h1234_62B7);
            chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_hold_last",  {31'd0, out_last}, 32'd0);
            chk("bp_hold_inrdy", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        tick();
        chk_word("bp_w2", 32'hFFF2_8293, 1'b1, 1'b0);
        tick();
        chk("bp_done_valid", {31'd0, out_valid}, 32'd0);

        // Jump / Store / UpperImm packing and error detection
        send("jal_big", 32'h0000_006F, FMT_JUMP, 32'h0010_0000, 1'b0);
        chk("jal_big_err", {31'd0, out_err}, 32'd1);
        send("jal_800", 32'h0000_006F, FMT_JUMP, 32'h0000_0800, 1'b0);
        chk_word("jal_800", 32'h0010_006F, 1'b1, 1'b0);
        send("st_m4", 32'h0000_2023, FMT_STORE, 32'hFFFF_FFFC, 1'b0);
        chk_word("st_m4", 32'hFE00_2E23, 1'b1, 1'b0);
        send("lui_800", 32'h0000_0037, FMT_UPPER, 32'h0000_0800, 1'b0);
        chk("lui_800_err", {31'd0, out_err}, 32'd1);
        send("lui_ok", 32'h0000_0037, FMT_UPPER, 32'hABCD_E000, 1'b0);
        chk_word("lui_ok", 32'hABCD_E037, 1'b1, 1'b0);
        tick();
        chk("cnt_3", {24'd0, err_count}, 32'd3);

        // Out-of-range Imm without expansion: truncated single word with error
        send("imm_2048", 32'h0000_0013, FMT_IMM, 32'd2048, 1'b0);
        chk_word("imm_2048", 32'h8000_0013, 1'b1, 1'b1);
        // Lower boundary fits, so no expansion even when allowed
        send("imm_min", 32'h0000_0013, FMT_IMM, 32'hFFFF_F800, 1'b1);
        chk_word("imm_min", 32'h8000_0013, 1'b1, 1'b0);
        tick();
        chk("cnt_4", {24'd0, err_count}, 32'd4);

        // Expansion with rd = x0 and wrap of imm + 0x800
        send("wrap", 32'h0000_0013, FMT_IMM, 32'h7FFF_F800, 1'b1);
        chk_word("wrap_w1", 32'h8000_0037, 1'b0, 1'b0);
        tick();
        chk_word("wrap_w2", 32'h8000_0013, 1'b1, 1'b0);
        tick();

        // Reset while the second word is pending
        out_ready = 1'b0;
        send("rst_mid", 32'h0000_0293, FMT_IMM, 32'h1234_5FFF, 1'b1);
        chk("rst_mid_w1", out_instr, 32'h1234_62B7);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_mid_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_mid_cnt",   {24'd0, err_count}, 32'd0);
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        tick();
        send("post_rst", 32'h0000_0293, FMT_IMM, 32'hFFFF_FFFF, 1'b0);
        chk_word("post_rst", 32'hFFF0_0293, 1'b1, 1'b0);
        tick();
        chk("post_rst_idle", {31'd0, out_valid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_imm_encoder
`default_nettype wire
